// File: rtl/prog_regular_pulse_gen.sv
// prog_regular_pulse_gen: programmable periodic/one-shot pulse generator with shadowed period/width config
// Ports: clk, rst_n (async, active-low); en run enable; mode 0=periodic 1=one-shot; trig one-shot start;
//        cfg_we/cfg_period/cfg_width shadow config write; pulse_out, period_done registered outputs;
//        busy high in RUN; cfg_err sticky flag set when the last config write was clamped.
module prog_regular_pulse_gen #(
   parameter int CNT_W          = 8,
   parameter int DEFAULT_PERIOD = 20,
   parameter int DEFAULT_WIDTH  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic             trig,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_width,
   output logic             pulse_out,
   output logic             period_done,
   output logic             busy,
   output logic             cfg_err
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
   localparam logic [CNT_W-1:0] P_DEF = CNT_W'(DEFAULT_PERIOD);
   localparam logic [CNT_W-1:0] W_DEF = CNT_W'(DEFAULT_WIDTH);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] ph_q, ph_d, p_q, p_d, w_q, w_d, ps_q, ps_d, ws_q, ws_d, p_san, w_san;
   logic             run_mode_q, run_mode_d, err_q, err_d, pulse_q, pulse_d, done_q, done_d;
   logic             start, wrap, load;
   always_comb begin
      p_san      = (cfg_period < TWO) ? TWO : cfg_period;
      w_san      = (cfg_width > p_san - ONE) ? p_san - ONE : cfg_width;
      ps_d       = cfg_we ? p_san : ps_q;
      ws_d       = cfg_we ? w_san : ws_q;
      err_d      = cfg_we ? ((cfg_period < TWO) || (cfg_width > p_san - ONE)) : err_q;
      start      = (state_q == IDLE) && en && (!mode || trig);
      wrap       = (state_q == RUN) && (ph_q == p_q - ONE);
      // shadow is taken from ps_d/ws_d so a write on a start/wrap edge goes straight through
      load       = start || wrap;
      p_d        = load ? ps_d : p_q;
      w_d        = load ? ws_d : w_q;
      run_mode_d = start ? mode : run_mode_q;
      state_d    = (state_q == IDLE) ? (start ? RUN : IDLE)
                                     : ((!en || (wrap && run_mode_q)) ? IDLE : RUN);
      ph_d       = (state_q == RUN && state_d == RUN && !wrap) ? ph_q + ONE : '0;
      // outputs are decoded from next state so the port flops carry the current-cycle value
      pulse_d    = (state_d == RUN) && (ph_d >= p_d - w_d);
      done_d     = (state_d == RUN) && (ph_d == p_d - ONE);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ph_q       <= '0;
         run_mode_q <= 1'b0;
         p_q        <= P_DEF;
         w_q        <= W_DEF;
         ps_q       <= P_DEF;
         ws_q       <= W_DEF;
         err_q      <= 1'b0;
         pulse_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         run_mode_q <= run_mode_d;
         p_q        <= p_d;
         w_q        <= w_d;
         ps_q       <= ps_d;
         ws_q       <= ws_d;
         err_q      <= err_d;
         pulse_q    <= pulse_d;
         done_q     <= done_d;
      end
   end
   assign pulse_out   = pulse_q;
   assign period_done = done_q;
   assign busy        = (state_q == RUN);
   assign cfg_err     = err_q;
endmodule

// File: tb/tb_prog_regular_pulse_gen.sv
// tb_prog_regular_pulse_gen: directed vector bench for prog_regular_pulse_gen
module tb_prog_regular_pulse_gen;
   logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, mode = 1'b0, trig = 1'b0, cfg_we = 1'b0;
   logic [7:0] cfg_period = 8'd0, cfg_width = 8'd0;
   logic       pulse_out, period_done, busy, cfg_err;
   int         n_vec = 0, n_err = 0;
   typedef struct {
      logic       en, mode, trig, we;
      logic [7:0] per, wid;
      logic       pu, dn, bz, er;
   } vec_t;
   vec_t tv[$];
   prog_regular_pulse_gen #(.CNT_W(8), .DEFAULT_PERIOD(20), .DEFAULT_WIDTH(1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .trig(trig), .cfg_we(cfg_we),
      .cfg_period(cfg_period), .cfg_width(cfg_width), .pulse_out(pulse_out),
      .period_done(period_done), .busy(busy), .cfg_err(cfg_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic run_check(input string tag, input int n, input int p, input int w, input int ph0);
      for (int i = 0; i < n; i++) begin
         int ph;
         step();
         ph = (ph0 + i) % p;
         chk($sformatf("%s.c%0d.pulse", tag, i), int'(pulse_out), int'(ph >= p - w));
         chk($sformatf("%s.c%0d.done", tag, i), int'(period_done), int'(ph == p - 1));
         chk($sformatf("%s.c%0d.busy", tag, i), int'(busy), 1);
      end
   endtask
   task automatic add(input logic e, m, t, we, input int per, wid, input logic pu, dn, bz, er);
      vec_t v;
      v.en = e; v.mode = m; v.trig = t; v.we = we;
      v.per = 8'(per); v.wid = 8'(wid);
      v.pu = pu; v.dn = dn; v.bz = bz; v.er = er;
      tv.push_back(v);
   endtask
   initial begin
      add(0,0,0,0, 0,0, 0,0,0,0);
      add(0,1,0,1, 8,3, 0,0,0,0);
      add(1,1,0,0, 0,0, 0,0,0,0);
      add(1,1,1,0, 0,0, 0,0,1,0);
      add(1,1,0,0, 0,0, 0,0,1,0);
      add(1,1,1,0, 0,0, 0,0,1,0);
      add(1,0,0,0, 0,0, 0,0,1,0);
      add(1,1,0,0, 0,0, 0,0,1,0);
      add(1,1,0,0, 0,0, 1,0,1,0);
      add(1,1,0,0, 0,0, 1,0,1,0);
      add(1,1,0,0, 0,0, 1,1,1,0);
      add(1,1,0,0, 0,0, 0,0,0,0);
      add(1,1,0,0, 0,0, 0,0,0,0);
      add(1,0,0,0, 0,0, 0,0,1,0);
      add(1,1,0,0, 0,0, 0,0,1,0);
      add(1,1,0,0, 0,0, 0,0,1,0);
      add(1,1,0,0, 0,0, 0,0,1,0);
      add(1,1,0,0, 0,0, 0,0,1,0);
      add(1,1,0,0, 0,0, 1,0,1,0);
      add(1,1,0,0, 0,0, 1,0,1,0);
      add(1,1,0,0, 0,0, 1,1,1,0);
      add(1,1,0,0, 0,0, 0,0,1,0);
      add(0,0,0,0, 0,0, 0,0,0,0);
      add(0,0,0,1, 0,0, 0,0,0,1);
      add(0,0,0,1, 3,2, 0,0,0,0);
      add(0,0,0,1, 3,3, 0,0,0,1);
      add(0,0,0,1, 4,9, 0,0,0,1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst.pulse", int'(pulse_out), 0);
      chk("rst.done", int'(period_done), 0);
      chk("rst.busy", int'(busy), 0);
      chk("rst.err", int'(cfg_err), 0);
      rst_n = 1'b1;
      en = 1'b1;
      run_check("dflt", 100, 20, 1, 0);
      chk("dflt.err", int'(cfg_err), 0);
      run_check("pre", 10, 20, 1, 0);
      cfg_we = 1'b1; cfg_period = 8'd5; cfg_width = 8'd2;
      run_check("wr5", 1, 20, 1, 10);
      cfg_we = 1'b0;
      chk("wr5.err", int'(cfg_err), 0);
      run_check("old20", 9, 20, 1, 11);
      run_check("new5", 15, 5, 2, 0);
      cfg_we = 1'b1; cfg_period = 8'd1; cfg_width = 8'd9;
      run_check("clamp", 1, 2, 1, 0);
      cfg_we = 1'b0;
      chk("clamp.err", int'(cfg_err), 1);
      run_check("p2", 5, 2, 1, 1);
      cfg_we = 1'b1; cfg_period = 8'd10; cfg_width = 8'd4;
      run_check("legal", 1, 10, 4, 0);
      cfg_we = 1'b0;
      chk("legal.err", int'(cfg_err), 0);
      run_check("p10", 19, 10, 4, 1);
      cfg_we = 1'b1; cfg_period = 8'd6; cfg_width = 8'd0;
      run_check("w0", 1, 6, 0, 0);
      cfg_we = 1'b0;
      run_check("p6", 17, 6, 0, 1);
      chk("p6.err", int'(cfg_err), 0);
      foreach (tv[i]) begin
         en = tv[i].en; mode = tv[i].mode; trig = tv[i].trig;
         cfg_we = tv[i].we; cfg_period = tv[i].per; cfg_width = tv[i].wid;
         step();
         chk($sformatf("v%0d.pulse", i), int'(pulse_out), int'(tv[i].pu));
         chk($sformatf("v%0d.done", i), int'(period_done), int'(tv[i].dn));
         chk($sformatf("v%0d.busy", i), int'(busy), int'(tv[i].bz));
         chk($sformatf("v%0d.err", i), int'(cfg_err), int'(tv[i].er));
      end
      cfg_we = 1'b0; en = 1'b1; mode = 1'b0; trig = 1'b0;
      run_check("p4", 3, 4, 3, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.pulse", int'(pulse_out), 0);
      chk("arst.done", int'(period_done), 0);
      chk("arst.busy", int'(busy), 0);
      chk("arst.err", int'(cfg_err), 0);
      #1 rst_n = 1'b1;
      run_check("restart", 20, 20, 1, 0);
      run_check("toph10", 11, 20, 1, 0);
      en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         chk($sformatf("endrop.c%0d.pulse", i), int'(pulse_out), 0);
         chk($sformatf("endrop.c%0d.done", i), int'(period_done), 0);
         chk($sformatf("endrop.c%0d.busy", i), int'(busy), 0);
      end
      en = 1'b1;
      run_check("reen", 20, 20, 1, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
